// File: rtl/matmul_pkg.sv
// Shared types and address helpers for the matrix-multiply sequencer.
package matmul_pkg;

  typedef enum logic [3:0] {
    IDLE,
    LOAD,
    CLR,
    RD_A,
    RD_B,
    CAP_B,
    MAC,
    WR,
    OUT_RD,
    OUT_V,
    FIN
  } state_t;

  // Row-major layout: A occupies [0, N*N), B follows at N*N; C has its own memory.
  function automatic int unsigned a_addr(input int unsigned i, input int unsigned k,
                                         input int unsigned n);
    return i * n + k;
  endfunction

  function automatic int unsigned b_addr(input int unsigned k, input int unsigned j,
                                         input int unsigned n);
    return n * n + k * n + j;
  endfunction

  function automatic int unsigned c_addr(input int unsigned i, input int unsigned j,
                                         input int unsigned n);
    return i * n + j;
  endfunction

endpackage

// File: rtl/matmul_idx_cnt.sv
// Nested i/j/k index counter shared by the compute and readout phases.
module matmul_idx_cnt #(
  parameter int unsigned N  = 3,
  parameter int unsigned IW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clr,
  input  logic          i_clr_k,
  input  logic          i_inc_k,
  input  logic          i_inc_ij,
  output logic [IW-1:0] o_i,
  output logic [IW-1:0] o_j,
  output logic [IW-1:0] o_k,
  output logic          o_k_last,
  output logic          o_ij_last
);

  localparam logic [IW-1:0] LAST = IW'(N - 1);

  logic [IW-1:0] r_i, r_j, r_k;
  logic          w_i_last, w_j_last;

  assign w_i_last  = (r_i == LAST);
  assign w_j_last  = (r_j == LAST);
  assign o_k_last  = (r_k == LAST);
  assign o_ij_last = w_i_last & w_j_last;
  assign o_i       = r_i;
  assign o_j       = r_j;
  assign o_k       = r_k;

  // j is the inner index; i advances on j wrap and wraps itself after the last row.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_i <= '0;
      r_j <= '0;
      r_k <= '0;
    end else if (i_clr) begin
      r_i <= '0;
      r_j <= '0;
      r_k <= '0;
    end else begin
      if (i_clr_k) begin
        r_k <= '0;
      end else if (i_inc_k && !o_k_last) begin
        r_k <= r_k + IW'(1);
      end
      if (i_inc_ij) begin
        if (w_j_last) begin
          r_j <= '0;
          r_i <= w_i_last ? '0 : r_i + IW'(1);
        end else begin
          r_j <= r_j + IW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/matmul_seq.sv
// Control sequencer for the NxN matrix multiply: load, compute C = A*B, stream results out.
module matmul_seq
  import matmul_pkg::*;
#(
  parameter int unsigned N  = 3,
  parameter int unsigned AW = 5,
  parameter int unsigned RW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic          load_valid,
  output logic          load_ready,
  output logic          in_we,
  output logic          in_re,
  output logic [AW-1:0] in_addr,
  output logic          a_we,
  output logic          b_we,
  output logic          acc_clr,
  output logic          acc_en,
  output logic          res_we,
  output logic          res_re,
  output logic [RW-1:0] res_addr,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy,
  output logic          done
);

  localparam int unsigned   IW      = $clog2(N);
  localparam logic [AW-1:0] LD_LAST = AW'(2 * N * N - 1);

  state_t        r_state, w_state_nxt;
  logic [AW-1:0] r_ld;
  logic          w_ld_inc, w_ld_clr;
  logic          w_cnt_clr, w_clr_k, w_inc_k, w_inc_ij;
  logic          w_k_last, w_ij_last;
  logic [IW-1:0] w_i, w_j, w_k;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_ld <= '0;
    else if (w_ld_clr) r_ld <= '0;
    else if (w_ld_inc) r_ld <= r_ld + AW'(1);
  end

  matmul_idx_cnt #(.N(N), .IW(IW)) u_idx (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (w_cnt_clr),
    .i_clr_k   (w_clr_k),
    .i_inc_k   (w_inc_k),
    .i_inc_ij  (w_inc_ij),
    .o_i       (w_i),
    .o_j       (w_j),
    .o_k       (w_k),
    .o_k_last  (w_k_last),
    .o_ij_last (w_ij_last)
  );

  always_comb begin
    w_state_nxt = r_state;
    load_ready  = 1'b0;
    in_we       = 1'b0;
    in_re       = 1'b0;
    in_addr     = '0;
    a_we        = 1'b0;
    b_we        = 1'b0;
    acc_clr     = 1'b0;
    acc_en      = 1'b0;
    res_we      = 1'b0;
    res_re      = 1'b0;
    res_addr    = '0;
    out_valid   = 1'b0;
    done        = 1'b0;
    busy        = (r_state != IDLE);
    w_ld_inc    = 1'b0;
    w_ld_clr    = 1'b0;
    w_cnt_clr   = 1'b0;
    w_clr_k     = 1'b0;
    w_inc_k     = 1'b0;
    w_inc_ij    = 1'b0;

    case (r_state)
      IDLE: if (start) w_state_nxt = LOAD;
      LOAD: begin
        load_ready = 1'b1;
        in_addr    = r_ld;
        in_we      = load_valid;
        if (load_valid) begin
          if (r_ld == LD_LAST) begin
            w_ld_clr    = 1'b1;
            w_state_nxt = CLR;
          end else begin
            w_ld_inc = 1'b1;
          end
        end
      end
      CLR: begin
        acc_clr     = 1'b1;
        w_clr_k     = 1'b1;
        w_state_nxt = RD_A;
      end
      RD_A: begin
        in_re       = 1'b1;
        in_addr     = AW'(a_addr(32'(w_i), 32'(w_k), N));
        w_state_nxt = RD_B;
      end
      // A data returns this cycle while the B read is issued.
      RD_B: begin
        in_re       = 1'b1;
        in_addr     = AW'(b_addr(32'(w_k), 32'(w_j), N));
        a_we        = 1'b1;
        w_state_nxt = CAP_B;
      end
      CAP_B: begin
        b_we        = 1'b1;
        w_state_nxt = MAC;
      end
      MAC: begin
        acc_en = 1'b1;
        if (!w_k_last) begin
          w_inc_k     = 1'b1;
          w_state_nxt = RD_A;
        end else begin
          w_state_nxt = WR;
        end
      end
      WR: begin
        res_we      = 1'b1;
        res_addr    = RW'(c_addr(32'(w_i), 32'(w_j), N));
        w_inc_ij    = 1'b1;
        w_state_nxt = w_ij_last ? OUT_RD : CLR;
      end
      OUT_RD: begin
        res_re      = 1'b1;
        res_addr    = RW'(c_addr(32'(w_i), 32'(w_j), N));
        w_state_nxt = OUT_V;
      end
      OUT_V: begin
        out_valid = 1'b1;
        res_addr  = RW'(c_addr(32'(w_i), 32'(w_j), N));
        if (out_ready) begin
          w_inc_ij    = 1'b1;
          w_state_nxt = w_ij_last ? FIN : OUT_RD;
        end
      end
      FIN: begin
        done        = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase

    // Cancel overrides every transition and counter update.
    if (abort && (r_state != IDLE)) begin
      w_state_nxt = IDLE;
      w_cnt_clr   = 1'b1;
      w_ld_clr    = 1'b1;
      w_ld_inc    = 1'b0;
      w_clr_k     = 1'b0;
      w_inc_k     = 1'b0;
      w_inc_ij    = 1'b0;
    end
  end

endmodule

// File: tb/tb_matmul_seq.sv
// Directed bench for matmul_seq (N=3): timing, addressing, gaps, back-pressure, abort, reset.
module tb_matmul_seq;

  localparam int unsigned N  = 3;
  localparam int unsigned AW = 5;
  localparam int unsigned RW = 4;

  logic          clk = 1'b0;
  logic          rst, start, abort, load_valid, out_ready;
  logic          load_ready, in_we, in_re, a_we, b_we, acc_clr, acc_en;
  logic          res_we, res_re, out_valid, busy, done;
  logic [AW-1:0] in_addr;
  logic [RW-1:0] res_addr;

  always #5 clk = ~clk;

  matmul_seq #(.N(N), .AW(AW), .RW(RW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .load_valid(load_valid), .load_ready(load_ready),
    .in_we(in_we), .in_re(in_re), .in_addr(in_addr),
    .a_we(a_we), .b_we(b_we), .acc_clr(acc_clr), .acc_en(acc_en),
    .res_we(res_we), .res_re(res_re), .res_addr(res_addr),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done)
  );

  int total = 0;
  int bad   = 0;

  int ld_addr[$], ra_q[$], rb_q[$], res_cyc[$], res_adr[$], beat_adr[$];
  int n_load_ready, first_clr, last_load, last_beat, done_cyc, n_done, n_stall, stall_bad;
  bit aborted, hit_outv;

  function automatic int seq_errs(input int q[$], input int base, input int stride,
                                  input int n);
    int e = 0;
    if (q.size() != n) e++;
    for (int x = 0; x < q.size() && x < n; x++) if (q[x] != base + stride * x) e++;
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one job from IDLE, recording what the sequencer does each cycle (c=0 is first LOAD cycle).
  task automatic do_job(input bit gaps, input bit hold_start, input int bp_beat,
                        input int bp_len, input int abort_elem, input bit stop_outv);
    ld_addr.delete(); ra_q.delete(); rb_q.delete();
    res_cyc.delete(); res_adr.delete(); beat_adr.delete();
    n_load_ready = 0; first_clr = -1; last_load = -1; last_beat = -1;
    done_cyc = -1; n_done = 0; n_stall = 0; stall_bad = 0;
    aborted = 1'b0; hit_outv = 1'b0;
    start = 1'b1;
    step();
    if (!hold_start) start = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      load_valid = gaps ? ((c % 2) == 0) : 1'b1;
      out_ready  = !((beat_adr.size() == bp_beat) && (n_stall < bp_len));
      #1;
      if (load_ready) n_load_ready++;
      if (in_we) begin ld_addr.push_back(int'(in_addr)); last_load = c; end
      if (acc_clr && first_clr < 0) first_clr = c;
      if (in_re && !a_we) ra_q.push_back(int'(in_addr));
      if (in_re && a_we)  rb_q.push_back(int'(in_addr));
      if (res_we) begin res_cyc.push_back(c); res_adr.push_back(int'(res_addr)); end
      if (out_valid && stop_outv) begin hit_outv = 1'b1; break; end
      if (out_valid && !out_ready) begin
        n_stall++;
        if (int'(res_addr) != bp_beat) stall_bad++;
      end
      if (out_valid && out_ready) begin beat_adr.push_back(int'(res_addr)); last_beat = c; end
      if (abort_elem >= 0 && res_cyc.size() == abort_elem && acc_en) begin
        abort = 1'b1; aborted = 1'b1;
        step();
        abort = 1'b0;
        break;
      end
      if (done) begin
        n_done++; done_cyc = c;
        start = 1'b0;
        step();
        break;
      end
      step();
    end
    start = 1'b0; load_valid = 1'b0; out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; load_valid = 1'b0; out_ready = 1'b0;
    #12;
    total++;
    if ({load_ready, in_we, in_re, in_addr, a_we, b_we, acc_clr, acc_en, res_we, res_re,
         res_addr, out_valid, busy, done} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: busy=%b in_addr=%0d res_addr=%0d want all 0", busy, in_addr, res_addr);
    end
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    do_job(1'b0, 1'b0, -1, 0, -1, 1'b0);
    total++;
    if (n_load_ready !== 18) begin bad++; $display("FAIL basic_load_ready_cycles: got %0d want 18", n_load_ready); end
    total++;
    if (seq_errs(ld_addr, 0, 1, 18) !== 0) begin bad++; $display("FAIL basic_load_addrs: %0d words, %0d errs want 0..17", ld_addr.size(), seq_errs(ld_addr, 0, 1, 18)); end
    total++;
    if (first_clr !== 18) begin bad++; $display("FAIL basic_first_clr: got cycle %0d want 18", first_clr); end
    total++;
    if (seq_errs(res_cyc, 31, 14, 9) !== 0) begin bad++; $display("FAIL basic_res_we_timing: %0d pulses first=%0d want 9 at 31+14e", res_cyc.size(), (res_cyc.size() > 0) ? res_cyc[0] : -1); end
    total++;
    if (seq_errs(res_adr, 0, 1, 9) !== 0) begin bad++; $display("FAIL basic_res_addrs: %0d errs want 0..8", seq_errs(res_adr, 0, 1, 9)); end
    total++;
    if (seq_errs(beat_adr, 0, 1, 9) !== 0) begin bad++; $display("FAIL basic_out_beats: %0d beats want 9 with addr 0..8", beat_adr.size()); end
    total++;
    if (done_cyc !== 162 || n_done !== 1) begin bad++; $display("FAIL basic_done: cycle %0d count %0d want 162 count 1 (last beat %0d)", done_cyc, n_done, last_beat); end
    total++;
    if ({busy, done} !== 2'b00) begin bad++; $display("FAIL basic_idle_after: busy=%b done=%b want 0 0", busy, done); end
  endtask

  task automatic test_addr_c12();
    int exp_a[3] = '{3, 4, 5};
    int exp_b[3] = '{11, 14, 17};
    int ga, gb;
    for (int k = 0; k < 3; k++) begin
      ga = (ra_q.size() > 15 + k) ? ra_q[15 + k] : -1;
      gb = (rb_q.size() > 15 + k) ? rb_q[15 + k] : -1;
      total++;
      if (ga !== exp_a[k]) begin bad++; $display("FAIL c12_rd_a_k%0d: got %0d want %0d", k, ga, exp_a[k]); end
      total++;
      if (gb !== exp_b[k]) begin bad++; $display("FAIL c12_rd_b_k%0d: got %0d want %0d", k, gb, exp_b[k]); end
    end
  endtask

  task automatic test_load_gaps();
    do_job(1'b1, 1'b0, -1, 0, -1, 1'b0);
    total++;
    if (seq_errs(ld_addr, 0, 1, 18) !== 0) begin bad++; $display("FAIL gaps_load_addrs: %0d words want 0..17", ld_addr.size()); end
    total++;
    if (last_load !== 34 || first_clr !== 35) begin bad++; $display("FAIL gaps_clr_timing: last load %0d clr %0d want 34 35", last_load, first_clr); end
    total++;
    if (seq_errs(res_cyc, 48, 14, 9) !== 0) begin bad++; $display("FAIL gaps_res_we_timing: %0d pulses want 9 at 48+14e", res_cyc.size()); end
    total++;
    if (done_cyc !== 179) begin bad++; $display("FAIL gaps_done: got %0d want 179", done_cyc); end
  endtask

  task automatic test_back_pressure();
    do_job(1'b0, 1'b0, 4, 5, -1, 1'b0);
    total++;
    if (n_stall !== 5 || stall_bad !== 0) begin bad++; $display("FAIL bp_stall: stalled %0d addr errs %0d want 5 0", n_stall, stall_bad); end
    total++;
    if (seq_errs(beat_adr, 0, 1, 9) !== 0) begin bad++; $display("FAIL bp_beats: %0d beats want 9 with addr 0..8", beat_adr.size()); end
    total++;
    if (last_beat !== 166 || done_cyc !== 167) begin bad++; $display("FAIL bp_done: last beat %0d done %0d want 166 167", last_beat, done_cyc); end
  endtask

  task automatic test_abort();
    int strobes = 0;
    do_job(1'b0, 1'b0, -1, 0, 5, 1'b0);
    total++;
    if (aborted !== 1'b1 || res_cyc.size() !== 5) begin bad++; $display("FAIL abort_point: aborted=%b writes %0d want 1 5", aborted, res_cyc.size()); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy: got %b want 0", busy); end
    for (int c = 0; c < 30; c++) begin
      if (res_we || done || busy || in_we) strobes++;
      step();
    end
    total++;
    if (strobes !== 0) begin bad++; $display("FAIL abort_quiet: got %0d active cycles want 0", strobes); end
    do_job(1'b0, 1'b0, -1, 0, -1, 1'b0);
    total++;
    if (seq_errs(ld_addr, 0, 1, 18) !== 0 || seq_errs(res_adr, 0, 1, 9) !== 0 || n_done !== 1) begin
      bad++; $display("FAIL abort_rerun: loads %0d writes %0d done %0d want 18 9 1", ld_addr.size(), res_adr.size(), n_done);
    end
  endtask

  task automatic test_rst_mid();
    do_job(1'b0, 1'b1, -1, 0, -1, 1'b1);
    total++;
    if (hit_outv !== 1'b1 || seq_errs(ld_addr, 0, 1, 18) !== 0) begin
      bad++; $display("FAIL held_start_load: reached outv %b loads %0d want 1 18", hit_outv, ld_addr.size());
    end
    rst = 1'b1;
    #1;
    total++;
    if ({load_ready, in_we, in_re, in_addr, a_we, b_we, acc_clr, acc_en, res_we, res_re,
         res_addr, out_valid, busy, done} !== '0) begin
      bad++; $display("FAIL rst_mid_outputs: out_valid=%b busy=%b res_addr=%0d want all 0", out_valid, busy, res_addr);
    end
    step();
    rst = 1'b0;
    step();
    do_job(1'b0, 1'b0, -1, 0, -1, 1'b0);
    total++;
    if (seq_errs(ld_addr, 0, 1, 18) !== 0 || seq_errs(beat_adr, 0, 1, 9) !== 0 || done_cyc !== 162) begin
      bad++; $display("FAIL rst_rerun: loads %0d beats %0d done %0d want 18 9 162", ld_addr.size(), beat_adr.size(), done_cyc);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_addr_c12();
    test_load_gaps();
    test_back_pressure();
    test_abort();
    test_rst_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
